// File: rtl/csidh_carry_seq.sv
// rtl/csidh_carry_seq.sv - streaming carry-propagation sequencer for reduced-radix limbs
//
// Optional feature macro: CSIDH_CARRY_LENCHK_EN (element length check driving err).
//
// Ports:
//   g_clk      in   clock, rising edge
//   g_resetn   in   asynchronous active-low reset
//   in_valid   in   input limb valid
//   in_ready   out  block can accept an input limb
//   in_data    in   signed 64-bit input limb, little-endian order
//   in_last    in   marks the most-significant limb of an element
//   out_valid  out  output limb valid
//   out_ready  in   consumer accepts the output limb
//   out_data   out  normalised limb (masked to RADIX bits, top limb unmasked)
//   out_last   out  marks the most-significant output limb
//   err        out  one-cycle length-error pulse (0 unless CSIDH_CARRY_LENCHK_EN)
module csidh_carry_seq #(
    parameter int RADIX = 57,
    parameter int NLIMB = 9
) (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        out_last,
    output logic        err
);

    localparam logic [63:0] MASK = (64'd1 << RADIX) - 64'd1;

    if (RADIX < 1 || RADIX > 63) begin : g_bad_radix
        $error("RADIX must be in 1..63");
    end
    if (NLIMB < 1) begin : g_bad_nlimb
        $error("NLIMB must be at least 1");
    end

    logic [63:0] acc;
    logic        acc_v;
    logic        acc_last;
    logic [63:0] carry;
    logic        oslot;
    logic        accept;
    logic        drain;

    // Sign-filled shift: a negative partial sum borrows from the next limb.
    assign carry    = 64'($signed(acc) >>> RADIX);
    assign oslot    = !out_valid || out_ready;
    // A completed top limb must drain before the next element may start.
    assign in_ready = oslot && !(acc_v && acc_last);
    assign accept   = in_valid && in_ready;
    assign drain    = acc_v && acc_last && oslot;

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            acc       <= 64'd0;
            acc_v     <= 1'b0;
            acc_last  <= 1'b0;
            out_data  <= 64'd0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            if (accept) begin
                acc_v    <= 1'b1;
                acc_last <= in_last;
                acc      <= acc_v ? (in_data + carry) : in_data;
            end else if (drain) begin
                acc_v    <= 1'b0;
                acc_last <= 1'b0;
            end

            if (accept && acc_v) begin
                out_data  <= acc & MASK;
                out_last  <= 1'b0;
                out_valid <= 1'b1;
            end else if (drain) begin
                // Top limb keeps the full signed carry.
                out_data  <= acc;
                out_last  <= 1'b1;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef CSIDH_CARRY_LENCHK_EN
    localparam int CW = $clog2(NLIMB + 1);

    logic [CW-1:0] cnt;
    logic          err_q;

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (accept) begin
                if (in_last) begin
                    cnt   <= '0;
                    err_q <= ((int'(cnt) + 1) != NLIMB);
                end else begin
                    cnt <= cnt + {{(CW-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
